// File: rtl/tick_pwm_gen.sv
// Tick-driven PWM generator with an Avalon-MM register slave.
// Period and duty are counted in timer ticks; shadow registers only update at a period boundary.
`timescale 1ns/1ps
module tick_pwm_gen #(
  parameter int              CNT_W      = 16,
  parameter logic [CNT_W-1:0] RESET_DUTY = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        pwm_out
);

  localparam int               DATA_W  = 16;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             enable_reg, enable_next;
  logic             irq_en_reg, irq_en_next;
  logic             invert_reg, invert_next;
  logic             one_shot_reg, one_shot_next;
  logic [CNT_W-1:0] period_pend_reg, period_pend_next;
  logic [CNT_W-1:0] duty_pend_reg, duty_pend_next;
  logic [CNT_W-1:0] period_act_reg, period_act_next;
  logic [CNT_W-1:0] duty_act_reg, duty_act_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;
  logic             period_done_reg, period_done_next;
  logic             pwm_reg, pwm_next;
  logic [DATA_W-1:0] readdata_reg, readdata_next;

  logic       wr_en;
  logic [7:0] wr_sel;
  logic       period_zero;
  logic       wrap;

  assign wr_en = chipselect & ~write_n;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wr_dec
      assign wr_sel[gi] = wr_en && (address == 3'(gi));
    end
  endgenerate

  assign period_zero = (period_act_reg == '0);
  assign wrap = enable_reg & tick & ~period_zero & (count_reg == period_act_reg - CNT_ONE);

  always_comb begin
    enable_next      = enable_reg;
    irq_en_next      = irq_en_reg;
    invert_next      = invert_reg;
    one_shot_next    = one_shot_reg;
    period_pend_next = period_pend_reg;
    duty_pend_next   = duty_pend_reg;
    period_act_next  = period_act_reg;
    duty_act_next    = duty_act_reg;
    count_next       = count_reg;
    cycles_next      = cycles_reg;
    period_done_next = period_done_reg;
    pwm_next         = pwm_reg;
    readdata_next    = readdata_reg;

    if (!enable_reg || period_zero) begin
      count_next = '0;
    end else if (tick) begin
      count_next = wrap ? '0 : count_reg + CNT_ONE;
    end

    // Shadows see the pre-edge pending value, so a same-clock write waits for the next boundary.
    if (!enable_reg || period_zero || wrap) begin
      period_act_next = period_pend_reg;
      duty_act_next   = duty_pend_reg;
    end

    if (wr_sel[0]) period_done_next = 1'b0;
    if (wrap)      period_done_next = 1'b1;

    if (wrap) cycles_next = cycles_reg + CNT_ONE;
    if (wr_sel[5]) cycles_next = wrap ? CNT_ONE : '0;

    if (wrap && one_shot_reg) enable_next = 1'b0;
    if (wr_sel[1]) begin
      enable_next   = writedata[0];
      irq_en_next   = writedata[1];
      invert_next   = writedata[2];
      one_shot_next = writedata[3];
    end

    if (wr_sel[2]) period_pend_next = CNT_W'(writedata);
    if (wr_sel[3]) duty_pend_next   = CNT_W'(writedata);

    // Using the post-edge enable avoids a stray pulse on the one-shot stopping edge.
    if (enable_next) pwm_next = (count_next < duty_act_next) ^ invert_next;
    else             pwm_next = invert_next;

    if (chipselect && write_n) begin
      case (address)
        3'd0:    readdata_next = DATA_W'({enable_reg, period_done_reg});
        3'd1:    readdata_next = DATA_W'({one_shot_reg, invert_reg, irq_en_reg, enable_reg});
        3'd2:    readdata_next = DATA_W'(period_pend_reg);
        3'd3:    readdata_next = DATA_W'(duty_pend_reg);
        3'd4:    readdata_next = DATA_W'(count_reg);
        3'd5:    readdata_next = DATA_W'(cycles_reg);
        default: readdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg      <= 1'b0;
      irq_en_reg      <= 1'b0;
      invert_reg      <= 1'b0;
      one_shot_reg    <= 1'b0;
      period_pend_reg <= '0;
      duty_pend_reg   <= RESET_DUTY;
      period_act_reg  <= '0;
      duty_act_reg    <= RESET_DUTY;
      count_reg       <= '0;
      cycles_reg      <= '0;
      period_done_reg <= 1'b0;
      pwm_reg         <= 1'b0;
      readdata_reg    <= '0;
    end else begin
      enable_reg      <= enable_next;
      irq_en_reg      <= irq_en_next;
      invert_reg      <= invert_next;
      one_shot_reg    <= one_shot_next;
      period_pend_reg <= period_pend_next;
      duty_pend_reg   <= duty_pend_next;
      period_act_reg  <= period_act_next;
      duty_act_reg    <= duty_act_next;
      count_reg       <= count_next;
      cycles_reg      <= cycles_next;
      period_done_reg <= period_done_next;
      pwm_reg         <= pwm_next;
      readdata_reg    <= readdata_next;
    end
  end

  assign readdata = readdata_reg;
  assign pwm_out  = pwm_reg;
  assign irq      = period_done_reg & irq_en_reg;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Self-checking bench for tick_pwm_gen: bus reads are scored through an expected-value queue.
`timescale 1ns/1ps
module tb_tick_pwm_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = '0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;
  logic        pwm_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  localparam logic [2:0] A_STATUS = 3'd0, A_CONTROL = 3'd1, A_PERIOD = 3'd2,
                         A_DUTY = 3'd3, A_COUNT = 3'd4, A_CYCLES = 3'd5;

  tick_pwm_gen #(.CNT_W(16), .RESET_DUTY(16'd0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .chipselect(chipselect),
    .address(address), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-20s got 0x%04h", tag, got);
    end else begin
      $display("FAIL %-20s got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq(t, readdata, e);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic do_tick(input logic exp_pwm, input logic chk, input string tag);
    tick = 1'b1;
    @(posedge clk);
    #1;
    if (chk) check_eq(tag, 16'(pwm_out), 16'(exp_pwm));
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick_write(input logic [2:0] a, input logic [15:0] d);
    tick = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0; chipselect = 1'b0; write_n = 1'b1;
  endtask

  logic [15:0] t4_duty[4] = '{16'd0, 16'd5, 16'd0, 16'd5};
  logic        t4_inv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic        t4_exp[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #1 reset = 1'b1;
    #1;
    check_eq("rst readdata", readdata, 16'h0);
    check_eq("rst irq", 16'(irq), 16'h0);
    check_eq("rst pwm", 16'(pwm_out), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_DUTY, 16'h0, "rst DUTY");
    bus_read(A_CONTROL, 16'h0, "rst CONTROL");

    // T1: PERIOD=4 DUTY=1 -> high on 1 of 4 ticks
    bus_write(A_PERIOD, 16'd4);
    bus_write(A_DUTY, 16'd1);
    bus_write(A_CONTROL, 16'h1);
    check_eq("t1 pwm at enable", 16'(pwm_out), 16'h1);
    for (int k = 1; k <= 8; k++) do_tick((k % 4) == 0, 1'b1, $sformatf("t1 pwm tick%0d", k));
    bus_read(A_CYCLES, 16'd2, "t1 CYCLES");
    bus_read(A_STATUS, 16'h3, "t1 STATUS");
    bus_read(A_COUNT, 16'd0, "t1 COUNT");
    bus_read(A_PERIOD, 16'd4, "t1 PERIOD");

    // T2: duty change mid-period waits for the wrap
    do_tick(1'b0, 1'b1, "t2 pwm c1");
    bus_write(A_DUTY, 16'd3);
    bus_read(A_DUTY, 16'd3, "t2 DUTY");
    do_tick(1'b0, 1'b1, "t2 pwm c2 old duty");
    do_tick(1'b0, 1'b1, "t2 pwm c3");
    do_tick(1'b1, 1'b1, "t2 pwm wrap");
    do_tick(1'b1, 1'b1, "t2 pwm c1 new duty");
    do_tick(1'b1, 1'b1, "t2 pwm c2 new duty");
    do_tick(1'b0, 1'b1, "t2 pwm c3 new duty");

    // T3: one-shot with interrupt
    bus_write(A_CONTROL, 16'h0);
    bus_write(A_PERIOD, 16'd3);
    bus_write(A_DUTY, 16'd1);
    bus_write(A_STATUS, 16'h0);
    bus_write(A_CONTROL, 16'hB);
    check_eq("t3 irq before", 16'(irq), 16'h0);
    do_tick(1'b0, 1'b1, "t3 pwm c1");
    do_tick(1'b0, 1'b1, "t3 pwm c2");
    do_tick(1'b0, 1'b1, "t3 pwm stop idle");
    check_eq("t3 irq", 16'(irq), 16'h1);
    bus_read(A_CONTROL, 16'hA, "t3 CONTROL");
    bus_read(A_STATUS, 16'h1, "t3 STATUS");
    do_tick(1'b0, 1'b1, "t3 pwm after stop");
    do_tick(1'b0, 1'b0, "");
    bus_read(A_COUNT, 16'd0, "t3 COUNT held");
    bus_write(A_STATUS, 16'h0);
    check_eq("t3 irq cleared", 16'(irq), 16'h0);

    // T4: duty extremes, with and without invert
    bus_write(A_CONTROL, 16'h0);
    bus_write(A_PERIOD, 16'd4);
    for (int c = 0; c < 4; c++) begin
      bus_write(A_CONTROL, 16'h0);
      bus_write(A_DUTY, t4_duty[c]);
      bus_write(A_CONTROL, t4_inv[c] ? 16'h5 : 16'h1);
      for (int k = 0; k < 5; k++)
        do_tick(t4_exp[c], 1'b1, $sformatf("t4 case%0d tick%0d", c, k));
    end
    bus_write(A_CONTROL, 16'h0);
    bus_write(A_PERIOD, 16'd0);
    bus_write(A_CYCLES, 16'h0);
    bus_write(A_CONTROL, 16'h1);
    for (int k = 0; k < 10; k++) do_tick(1'b0, 1'b0, "");
    bus_read(A_COUNT, 16'd0, "t4 period0 COUNT");
    bus_read(A_CYCLES, 16'd0, "t4 period0 CYCLES");

    // T5: simultaneous events and CYCLES rollover
    bus_write(A_CONTROL, 16'h0);
    bus_write(A_PERIOD, 16'd2);
    bus_write(A_DUTY, 16'd1);
    bus_write(A_STATUS, 16'h0);
    bus_write(A_CYCLES, 16'h0);
    bus_write(A_CONTROL, 16'h1);
    do_tick(1'b0, 1'b1, "t5 pwm c1");
    tick_write(A_STATUS, 16'h0);
    bus_read(A_STATUS, 16'h3, "t5 STATUS set wins");
    bus_read(A_CYCLES, 16'd1, "t5 CYCLES after wrap");
    do_tick(1'b0, 1'b0, "");
    tick_write(A_CYCLES, 16'h0);
    bus_read(A_CYCLES, 16'd1, "t5 CYCLES clr+wrap");
    bus_write(A_CONTROL, 16'h0);
    bus_write(A_PERIOD, 16'd1);
    bus_write(A_CYCLES, 16'h0);
    bus_write(A_CONTROL, 16'h1);
    tick = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    bus_read(A_CYCLES, 16'hFFFF, "t5 CYCLES max");
    do_tick(1'b0, 1'b0, "");
    bus_read(A_CYCLES, 16'h0, "t5 CYCLES wrap");

    // T6: asynchronous reset mid-period
    bus_write(A_CONTROL, 16'h0);
    bus_write(A_PERIOD, 16'd4);
    bus_write(A_DUTY, 16'd3);
    bus_write(A_CONTROL, 16'h3);
    do_tick(1'b1, 1'b1, "t6 pwm c1");
    do_tick(1'b1, 1'b1, "t6 pwm c2");
    bus_read(A_COUNT, 16'd2, "t6 COUNT");
    check_eq("t6 irq before", 16'(irq), 16'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6 rst readdata", readdata, 16'h0);
    check_eq("t6 rst irq", 16'(irq), 16'h0);
    check_eq("t6 rst pwm", 16'(pwm_out), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STATUS, 16'h0, "t6 STATUS");
    bus_read(A_CONTROL, 16'h0, "t6 CONTROL");
    bus_read(A_PERIOD, 16'h0, "t6 PERIOD");
    bus_read(A_DUTY, 16'h0, "t6 DUTY");
    bus_read(A_COUNT, 16'h0, "t6 COUNT after");
    bus_read(A_CYCLES, 16'h0, "t6 CYCLES");
    bus_read(3'd6, 16'h0, "t6 addr6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
